alu_issue_stage: RTL
====================

# alu_issue_stage

Decode-and-issue stage that drives the RV32I integer ALU: accepts an instruction with its PC and register-file operands, decodes it into the ALU's 4-bit control code and operands, and presents the result through a registered valid/ready interface with a 2-entry skid buffer. It sits between the register-read stage and the ALU/writeback stage and is the sole producer of the ALU `control`/`d1`/`d2` inputs.

## Interface
- No parameters; XLEN is fixed at 32.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous pipeline flush; discards buffered and incoming work
- `in_valid`  in  1  upstream payload valid
- `in_ready`  out  1  stage can accept; registered, no combinational path from `out_ready`
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction PC
- `in_rs1_data`  in  32  rs1 value
- `in_rs2_data`  in  32  rs2 value
- `out_valid`  out  1  issue payload valid
- `out_ready`  in  1  ALU/writeback stage accepts
- `out_d1`  out  32  ALU operand 1
- `out_d2`  out  32  ALU operand 2
- `out_control`  out  4  ALU control code
- `out_rd`  out  5  destination register
- `out_we`  out  1  register write enable
- `out_illegal`  out  1  instruction not an ALU-class instruction or bad funct7
- `out_pc`  out  32  PC of issued instruction

## Operation
- ALU codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101; no other codes are ever emitted.
- OP (0110011): d1=rs1, d2=rs2. funct7=0000000 → control={0,funct3}. funct7=0100000 with funct3=000 → SUB; with funct3=101 → SRA. Any other funct7/funct3 pairing → illegal.
- OP-IMM (0010011): d1=rs1, d2=sign-extended imm[11:0]. funct3≠001/101 → control={0,funct3}. funct3=001 needs funct7=0000000 (SLL). funct3=101: funct7=0000000 → SRL, 0100000 → SRA; else illegal.
- LUI (0110111): d1=0, d2={instr[31:12],12'b0}, ADD. AUIPC (0010111): d1=pc, d2={instr[31:12],12'b0}, ADD.
- Any other opcode → illegal.
- Illegal: out_illegal=1, out_we=0, control=ADD, d1=d2=0; entry still issued (trap handled downstream).
- out_rd=instr[11:7]; out_we=1 only if legal and rd≠0.
- Decode happens before buffering; both entries hold decoded payload.
- Buffer states: EMPTY, ONE (main full), TWO (main+skid full). Accept = in_valid & in_ready; drain = out_valid & out_ready.
  - EMPTY: accept → ONE.
  - ONE: accept & drain → ONE (main replaced); accept & !drain → TWO; !accept & drain → EMPTY.
  - TWO: drain → ONE (skid→main); in_ready=0, so no accept is possible.
- out_valid = state≠EMPTY; in_ready = state≠TWO (registered).
- Order strictly preserved; no entry dropped or duplicated except by flush/reset.

## Timing
- Reset: state EMPTY, out_valid=0, in_ready=1, all payload outputs 0.
- Latency: accepted input appears on outputs the next cycle if the main entry is empty or draining.
- Payload outputs stable while out_valid=1 & out_ready=0.
- in_ready falls the cycle after entering TWO; rises the cycle after draining from TWO.
- flush (and rst) take priority over accept/drain: next cycle EMPTY, out_valid=0, in_ready=1; input presented in flush cycle is dropped.
- Reset mid-transfer: any buffered payload is discarded, not issued.

## Structure
- Shared package `alu_pkg`: ALU control code localparams (ALU_ADD … ALU_SRA), opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC), funct7 constants; imported by the ALU-side logic as well.
- One sub-module: `alu_issue_decode`, purely combinational instr/pc/rs1/rs2 → {d1,d2,control,rd,we,illegal}; top holds the skid buffer and state.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, all outputs 0 for 5 cycles.
- R-type sweep, out_ready=1: `sub x3,x1,x2` (0x402081B3), rs1=5, rs2=7 → next cycle control=1000, d1=5, d2=7, rd=3, we=1; `sra` → 1101; funct7=0000001 → illegal=1, we=0.
- I-type/U-type: `addi x1,x0,-1` → d2=0xFFFFFFFF, control=0000; `srai x5,x5,3` → 1101, d2[4:0]=3; `slli` with funct7=0100000 → illegal; `auipc x4,0x12345` at pc=0x100 → d1=0x100, d2=0x12345000; `addi x0,x0,0` → we=0.
- Backpressure: 3 back-to-back accepts with out_ready=0 → third refused (in_ready=0 after second); then out_ready=1 → issued in order 1,2,3 with payload held stable while stalled.
- Flush in TWO state with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed and same-cycle inputs never appear.
- Random valid/ready with scoreboard (≥10k instructions): output stream equals reference decode of accepted stream, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcode/funct constants and
// the decoded issue payload carried through the skid buffer.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [3:0]  control;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
      logic [31:0] pc;
   } issue_payload_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream/downstream handshake bundle of the ALU issue stage; the stage
// uses the slave view, the surrounding pipeline (or bench) the master view.
interface alu_issue_stage_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_d1;
   logic [31:0] out_d2;
   logic [3:0]  out_control;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;
   logic [31:0] out_pc;

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      output in_ready, out_valid, out_d1, out_d2, out_control, out_rd,
             out_we, out_illegal, out_pc
   );

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      input  in_ready, out_valid, out_d1, out_d2, out_control, out_rd,
             out_we, out_illegal, out_pc
   );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decode: instruction + operands into the
// ALU control code, operand pair, destination and legality.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0]    instr,
   input  logic [31:0]    pc,
   input  logic [31:0]    rs1_data,
   input  logic [31:0]    rs2_data,
   output issue_payload_t payload
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic        legal;
   logic [31:0] d1_raw;
   logic [31:0] d2_raw;
   logic [3:0]  control_raw;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};

   always_comb begin
      legal       = 1'b0;
      d1_raw      = '0;
      d2_raw      = '0;
      control_raw = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            d1_raw = rs1_data;
            d2_raw = rs2_data;
            if (funct7 == F7_BASE) begin
               legal       = 1'b1;
               control_raw = {1'b0, funct3};
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               legal       = 1'b1;
               control_raw = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
               legal       = 1'b1;
               control_raw = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            d1_raw = rs1_data;
            d2_raw = imm_i;
            // Shift immediates reuse the imm[11:5] field as funct7.
            if (funct3 == F3_SLL) begin
               legal       = (funct7 == F7_BASE);
               control_raw = ALU_SLL;
            end else if (funct3 == F3_SR) begin
               legal       = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               control_raw = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            end else begin
               legal       = 1'b1;
               control_raw = {1'b0, funct3};
            end
         end
         OPC_LUI: begin
            legal  = 1'b1;
            d2_raw = imm_u;
         end
         OPC_AUIPC: begin
            legal  = 1'b1;
            d1_raw = pc;
            d2_raw = imm_u;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      payload.d1      = legal ? d1_raw : '0;
      payload.d2      = legal ? d2_raw : '0;
      payload.control = legal ? control_raw : ALU_ADD;
      payload.rd      = instr[11:7];
      payload.we      = legal && (instr[11:7] != 5'd0);
      payload.illegal = !legal;
      payload.pc      = pc;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes incoming instructions and presents them through a
// registered valid/ready port backed by a two-entry (main + skid) buffer.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   alu_issue_stage_if.slave   bus
);

   buf_state_t     state_reg;
   buf_state_t     state_next;
   issue_payload_t main_reg;
   issue_payload_t skid_reg;
   issue_payload_t dec_payload;
   logic           in_ready_int;
   logic           out_valid_int;
   logic           accept;
   logic           drain;

   alu_issue_decode u_decode (
      .instr    (bus.in_instr),
      .pc       (bus.in_pc),
      .rs1_data (bus.in_rs1_data),
      .rs2_data (bus.in_rs2_data),
      .payload  (dec_payload)
   );

   // Handshake flags depend only on the state register, so in_ready has no
   // combinational path from out_ready.
   assign in_ready_int  = (state_reg != BUF_TWO);
   assign out_valid_int = (state_reg != BUF_EMPTY);
   assign accept        = bus.in_valid && in_ready_int;
   assign drain         = out_valid_int && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) state_reg <= BUF_EMPTY;
      else              state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BUF_EMPTY: if (accept) state_next = BUF_ONE;
         BUF_ONE: begin
            if (accept && !drain)      state_next = BUF_TWO;
            else if (!accept && drain) state_next = BUF_EMPTY;
         end
         BUF_TWO:   if (drain) state_next = BUF_ONE;
         default:   state_next = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_reg <= '0;
         skid_reg <= '0;
      end else begin
         case (state_reg)
            BUF_EMPTY: if (accept) main_reg <= dec_payload;
            BUF_ONE: begin
               if (accept && drain) main_reg <= dec_payload;
               else if (accept)     skid_reg <= dec_payload;
            end
            BUF_TWO:   if (drain) main_reg <= skid_reg;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.in_ready    = in_ready_int;
      bus.out_valid   = out_valid_int;
      bus.out_d1      = main_reg.d1;
      bus.out_d2      = main_reg.d2;
      bus.out_control = main_reg.control;
      bus.out_rd      = main_reg.rd;
      bus.out_we      = main_reg.we;
      bus.out_illegal = main_reg.illegal;
      bus.out_pc      = main_reg.pc;
   end

endmodule
